// File: rtl/register_file_param.sv
// Parametrised multi-read-port register file with a post-reset init engine.
// Reads are combinational with optional write bypass and a hardwired zero register.
module register_file_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 5,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1,
    parameter int PRESET_LO = 16,
    parameter int PRESET_HI = 21
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     ready,
    output logic                     wr_err
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_init_cnt;
    logic [ADDR_W:0]   w_init_cnt_nxt;
    logic              r_wr_err;
    logic              w_drop;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic [DATA_W-1:0] r_mem [DEPTH];

    function automatic logic [DATA_W-1:0] init_value(input logic [ADDR_W:0] cnt);
        if (int'(cnt) >= PRESET_LO && int'(cnt) <= PRESET_HI)
            return DATA_W'(int'(cnt) - PRESET_LO);
        return '0;
    endfunction

    // NOTE: every variable gets a default before the case so no latch is inferred.
    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_mem_we       = 1'b0;
        w_mem_addr     = wr_addr;
        w_mem_data     = wr_data;
        w_drop         = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_mem_we       = 1'b1;
                w_mem_addr     = r_init_cnt[ADDR_W-1:0];
                w_mem_data     = init_value(r_init_cnt);
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                w_drop         = wr_en;
                if (r_init_cnt == LAST_CNT)
                    w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                w_mem_we = wr_en && !(ZERO_REG != 0 && wr_addr == '0);
            end
            default: w_state_nxt = ST_INIT;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
            r_wr_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
            r_wr_err   <= w_drop;
        end
    end

    // NOTE: the array has no reset; the init engine fills every entry after reset instead.
    always_ff @(posedge clk) begin
        if (w_mem_we && rst)
            r_mem[w_mem_addr] <= w_mem_data;
    end

    assign ready  = (r_state == ST_RUN);
    assign wr_err = r_wr_err;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic [DATA_W-1:0] w_rdata;

        assign w_raddr = read_addr[g*ADDR_W +: ADDR_W];

        // Zero register and not-ready gating take priority over bypass.
        always_comb begin
            w_rdata = r_mem[w_raddr];
            if (BYPASS != 0 && wr_en && wr_addr == w_raddr)
                w_rdata = wr_data;
            if (ZERO_REG != 0 && w_raddr == '0)
                w_rdata = '0;
            if (!rst || r_state != ST_RUN)
                w_rdata = '0;
        end

        assign read_data[g*DATA_W +: DATA_W] = w_rdata;
    end

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: three instances cover the default,
// no-bypass/no-zero-register, and four-read-port configurations.
module tb_register_file_param;

    localparam int DW = 32;
    localparam int AW = 5;

    logic          clk     = 1'b0;
    logic          rst     = 1'b0;
    logic          wr_en   = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;

    logic [2*AW-1:0] ra_a = '0;
    logic [2*AW-1:0] ra_b = '0;
    logic [4*AW-1:0] ra_c = '0;
    logic [2*DW-1:0] rd_a;
    logic [2*DW-1:0] rd_b;
    logic [4*DW-1:0] rd_c;
    logic            ready_a, ready_b, ready_c;
    logic            wr_err_a, wr_err_b, wr_err_c;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    register_file_param u_dut_a (
        .clk(clk), .rst(rst), .read_addr(ra_a), .read_data(rd_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready_a), .wr_err(wr_err_a)
    );

    register_file_param #(.ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst(rst), .read_addr(ra_b), .read_data(rd_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready_b), .wr_err(wr_err_b)
    );

    register_file_param #(.NUM_RD(4)) u_dut_c (
        .clk(clk), .rst(rst), .read_addr(ra_c), .read_data(rd_c),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .ready(ready_c), .wr_err(wr_err_c)
    );

    task automatic test_reset;
        rst  = 1'b0;
        ra_a = {5'd21, 5'd17};
        ra_c = {4{5'd20}};
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if (rd_a !== '0) begin
            n_err++; $display("FAIL reset_rd_a: got %h expected 0", rd_a);
        end
        n_vec++;
        if (ready_a !== 1'b0 || wr_err_a !== 1'b0) begin
            n_err++; $display("FAIL reset_flags: ready=%b wr_err=%b expected 0 0", ready_a, wr_err_a);
        end
        @(negedge clk) rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (ready_a !== (i == 32)) begin
                n_err++; $display("FAIL ready_rise posedge %0d: got %b expected %b", i, ready_a, (i == 32));
            end
        end
        n_vec++;
        if (ready_b !== 1'b1 || ready_c !== 1'b1 || wr_err_c !== 1'b0) begin
            n_err++; $display("FAIL ready_bc: got %b %b err %b expected 1 1 0", ready_b, ready_c, wr_err_c);
        end
    endtask

    task automatic test_init_values;
        int addrs [8] = '{17, 21, 16, 5, 31, 15, 22, 20};
        int exps  [8] = '{1, 5, 0, 0, 0, 0, 0, 4};
        for (int i = 0; i < 8; i++) begin
            ra_a = {5'(addrs[i]), 5'(addrs[i])};
            ra_b = {5'(addrs[i]), 5'(addrs[i])};
            #1;
            n_vec++;
            if (rd_a !== {32'(exps[i]), 32'(exps[i])}) begin
                n_err++; $display("FAIL init_a addr %0d: got %h expected %0d on both ports", addrs[i], rd_a, exps[i]);
            end
            n_vec++;
            if (rd_b !== {32'(exps[i]), 32'(exps[i])}) begin
                n_err++; $display("FAIL init_b addr %0d: got %h expected %0d on both ports", addrs[i], rd_b, exps[i]);
            end
        end
    endtask

    task automatic test_bypass;
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_addr = 5'd3;
        wr_data = 32'hDEADBEEF;
        ra_a    = {5'd3, 5'd4};
        ra_b    = {5'd3, 5'd4};
        #1;
        n_vec++;
        if (rd_a !== {32'hDEADBEEF, 32'h0}) begin
            n_err++; $display("FAIL bypass_same_cycle: got %h expected deadbeef_00000000", rd_a);
        end
        n_vec++;
        if (rd_b !== 64'h0) begin
            n_err++; $display("FAIL nobypass_same_cycle: got %h expected 0", rd_b);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        ra_a  = {5'd4, 5'd3};
        ra_b  = {5'd4, 5'd3};
        #1;
        n_vec++;
        if (rd_a !== {32'h0, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL write_next_cycle_a: got %h expected 00000000_deadbeef", rd_a);
        end
        n_vec++;
        if (rd_b !== {32'h0, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL write_next_cycle_b: got %h expected 00000000_deadbeef", rd_b);
        end
        n_vec++;
        if (wr_err_a !== 1'b0) begin
            n_err++; $display("FAIL run_no_wr_err: got %b expected 0", wr_err_a);
        end
        // Both ports matching a write to a preset entry.
        wr_en   = 1'b1;
        wr_addr = 5'd17;
        wr_data = 32'h0BADF00D;
        ra_a    = {5'd17, 5'd17};
        #1;
        n_vec++;
        if (rd_a !== {2{32'h0BADF00D}}) begin
            n_err++; $display("FAIL bypass_both_ports: got %h expected 0badf00d twice", rd_a);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        n_vec++;
        if (rd_a !== {2{32'h0BADF00D}}) begin
            n_err++; $display("FAIL overwrite_preset: got %h expected 0badf00d twice", rd_a);
        end
    endtask

    task automatic test_zero_reg;
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_addr = 5'd0;
        wr_data = 32'h1234;
        ra_a    = {5'd0, 5'd0};
        ra_b    = {5'd0, 5'd0};
        #1;
        n_vec++;
        if (rd_a !== 64'h0) begin
            n_err++; $display("FAIL zero_reg_bypass: got %h expected 0", rd_a);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        #1;
        n_vec++;
        if (rd_a !== 64'h0 || wr_err_a !== 1'b0) begin
            n_err++; $display("FAIL zero_reg_write: got %h err %b expected 0 0", rd_a, wr_err_a);
        end
        n_vec++;
        if (rd_b !== {2{32'h1234}}) begin
            n_err++; $display("FAIL no_zero_reg_write: got %h expected 00001234 twice", rd_b);
        end
    endtask

    task automatic test_wr_err;
        bit seen;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        ra_a    = {5'd17, 5'd17};
        wr_en   = 1'b1;
        wr_addr = 5'd8;
        wr_data = 32'h55555555;
        #1;
        n_vec++;
        if (wr_err_a !== 1'b0 || rd_a !== 64'h0) begin
            n_err++; $display("FAIL init_quiet: err %b rd %h expected 0 0", wr_err_a, rd_a);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        n_vec++;
        if (wr_err_a !== 1'b1 || wr_err_b !== 1'b1) begin
            n_err++; $display("FAIL wr_err_pulse: got %b %b expected 1 1", wr_err_a, wr_err_b);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (wr_err_a !== 1'b0) begin
            n_err++; $display("FAIL wr_err_single: got %b expected 0", wr_err_a);
        end
        wr_en   = 1'b1;
        wr_addr = 5'd18;
        @(posedge clk);
        #1;
        wr_addr = 5'd8;
        n_vec++;
        if (wr_err_a !== 1'b1) begin
            n_err++; $display("FAIL wr_err_b2b_1: got %b expected 1", wr_err_a);
        end
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        n_vec++;
        if (wr_err_a !== 1'b1) begin
            n_err++; $display("FAIL wr_err_b2b_2: got %b expected 1", wr_err_a);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (wr_err_a !== 1'b0) begin
            n_err++; $display("FAIL wr_err_b2b_end: got %b expected 0", wr_err_a);
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = ready_a;
        end
        n_vec++;
        if (!seen) begin
            n_err++; $display("FAIL ready_timeout: ready=%b expected 1 within 40 cycles", ready_a);
        end
        ra_a = {5'd18, 5'd8};
        ra_b = {5'd18, 5'd8};
        #1;
        n_vec++;
        if (rd_a !== {32'd2, 32'd0}) begin
            n_err++; $display("FAIL dropped_write_a: got %h expected 00000002_00000000", rd_a);
        end
        n_vec++;
        if (rd_b !== {32'd2, 32'd0}) begin
            n_err++; $display("FAIL dropped_write_b: got %h expected 00000002_00000000", rd_b);
        end
        ra_a = {5'd3, 5'd3};
        #1;
        n_vec++;
        if (rd_a !== 64'h0) begin
            n_err++; $display("FAIL reinit_clears: got %h expected 0", rd_a);
        end
    endtask

    task automatic test_mid_reset;
        ra_a = {5'd17, 5'd17};
        ra_c = {4{5'd20}};
        #1;
        n_vec++;
        if (rd_a !== {2{32'd1}}) begin
            n_err++; $display("FAIL pre_reset_read: got %h expected 00000001 twice", rd_a);
        end
        rst = 1'b0;
        #1;
        n_vec++;
        if (rd_a !== 64'h0 || rd_c !== 128'h0 || ready_a !== 1'b0) begin
            n_err++; $display("FAIL async_reset: rd_a %h rd_c %h ready %b expected 0 0 0", rd_a, rd_c, ready_a);
        end
        @(negedge clk) rst = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        n_vec++;
        if (rd_c !== 128'h0 || ready_c !== 1'b0) begin
            n_err++; $display("FAIL mid_init_reset: rd_c %h ready %b expected 0 0", rd_c, ready_c);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        for (int i = 1; i <= 32; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (ready_c !== (i == 32)) begin
                n_err++; $display("FAIL ready_restart posedge %0d: got %b expected %b", i, ready_c, (i == 32));
            end
        end
        for (int k = 0; k < 4; k++) begin
            n_vec++;
            if (rd_c[k*DW +: DW] !== 32'd4) begin
                n_err++; $display("FAIL four_port port %0d: got %h expected 4", k, rd_c[k*DW +: DW]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_init_values();
        test_bypass();
        test_zero_reg();
        test_wr_err();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
